// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared types and default timing for the traffic phase scheduler.
// The pedestrian path is compiled in only when PED_WALK_EN is defined.
package traffic_pkg;

  localparam int unsigned TIMER_W       = 8;
  localparam int unsigned TICK_DIV_DEF  = 50_000_000;
  localparam int unsigned MIN_GREEN_DEF = 10;
  localparam int unsigned MAX_GREEN_DEF = 30;
  localparam int unsigned YELLOW_T_DEF  = 3;
  localparam int unsigned ALLRED_T_DEF  = 1;
  localparam int unsigned WALK_T_DEF    = 8;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_1   = 3'd2,
    PED_WALK    = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    ALL_RED_2   = 3'd6
  } phase_t;

  typedef struct packed {
    logic main_r;
    logic main_g;
    logic main_y;
    logic side_r;
    logic side_g;
    logic side_y;
    logic walk;
  } lamps_t;

  // Unlisted encodings fall back to red on both roads with walk off.
  function automatic lamps_t lamp_decode(input phase_t p);
    lamps_t l;
    l        = '0;
    l.main_g = (p == MAIN_GREEN);
    l.main_y = (p == MAIN_YELLOW);
    l.main_r = !(p == MAIN_GREEN || p == MAIN_YELLOW);
    l.side_g = (p == SIDE_GREEN);
    l.side_y = (p == SIDE_YELLOW);
    l.side_r = !(p == SIDE_GREEN || p == SIDE_YELLOW);
    l.walk   = (p == PED_WALK);
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Request and lamp bundle between the scheduler and its environment.
interface traffic_phase_scheduler_if;

  logic       side_req;
  logic       ped_req;
  logic       main_R;
  logic       main_G;
  logic       main_Y;
  logic       side_R;
  logic       side_G;
  logic       side_Y;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;

  modport master (
    output side_req, ped_req,
    input  main_R, main_G, main_Y, side_R, side_G, side_Y, walk, ped_ack, phase
  );

  modport slave (
    input  side_req, ped_req,
    output main_R, main_G, main_Y, side_R, side_G, side_Y, walk, ped_ack, phase
  );

endinterface

// File: rtl/traffic_phase_scheduler_tick_prescaler.sv
// Free-running divider: one-cycle tick every TICK_DIV clk_50 cycles.
module tick_prescaler
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk_50,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk_50) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven main/side phase scheduler with latched requests.
// Define PED_WALK_EN to include the pedestrian walk phase.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
  parameter int unsigned MIN_GREEN = MIN_GREEN_DEF,
  parameter int unsigned MAX_GREEN = MAX_GREEN_DEF,
  parameter int unsigned YELLOW_T  = YELLOW_T_DEF,
  parameter int unsigned ALLRED_T  = ALLRED_T_DEF,
  parameter int unsigned WALK_T    = WALK_T_DEF
) (
  input logic                      clk_50,
  input logic                      reset,
  traffic_phase_scheduler_if.slave bus
);

  localparam logic [TIMER_W-1:0] MIN_T = TIMER_W'(MIN_GREEN);
  localparam logic [TIMER_W-1:0] MAX_T = TIMER_W'(MAX_GREEN);
  localparam logic [TIMER_W-1:0] YEL_T = TIMER_W'(YELLOW_T);
  localparam logic [TIMER_W-1:0] AR_T  = TIMER_W'(ALLRED_T);
`ifdef PED_WALK_EN
  localparam logic [TIMER_W-1:0] WLK_T = TIMER_W'(WALK_T);
`endif

  logic               tick;
  phase_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d, timer_inc;
  logic               side_pend_q, side_pend_d;
  logic               demand;
  logic               ped_pend;
  lamps_t             lamps_q;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk_50 (clk_50),
    .reset  (reset),
    .tick   (tick)
  );

`ifdef PED_WALK_EN
  logic ped_pend_q, ped_pend_d;
  assign ped_pend = ped_pend_q;
  assign demand   = side_pend_q | ped_pend_q;
`else
  logic unused_ped;
  assign ped_pend   = 1'b0;
  assign demand     = side_pend_q;
  assign unused_ped = bus.ped_req ^ lamps_q.walk;
`endif

  // Thresholds compare against the post-increment count, so a phase of N
  // ticks leaves on its Nth tick.
  always_comb begin
    timer_inc = (timer_q == '1) ? timer_q : timer_q + TIMER_W'(1);
    state_d   = state_q;
    case (state_q)
      MAIN_GREEN:  if (tick && demand && timer_inc >= MIN_T) state_d = MAIN_YELLOW;
      MAIN_YELLOW: if (tick && timer_inc >= YEL_T) state_d = ALL_RED_1;
      ALL_RED_1:   if (tick && timer_inc >= AR_T) state_d = ped_pend ? PED_WALK : SIDE_GREEN;
`ifdef PED_WALK_EN
      PED_WALK:    if (tick && timer_inc >= WLK_T) state_d = side_pend_q ? SIDE_GREEN : ALL_RED_2;
`endif
      SIDE_GREEN: begin
        if (tick && (timer_inc >= MAX_T || (!bus.side_req && timer_inc >= MIN_T))) begin
          state_d = SIDE_YELLOW;
        end
      end
      SIDE_YELLOW: if (tick && timer_inc >= YEL_T) state_d = ALL_RED_2;
      ALL_RED_2:   if (tick && timer_inc >= AR_T) state_d = MAIN_GREEN;
      default:     state_d = MAIN_GREEN;
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (tick) begin
      timer_d = timer_inc;
    end else begin
      timer_d = timer_q;
    end

    // Entry clear dominates a same-cycle request: it counts as served.
    side_pend_d = (state_d == SIDE_GREEN && state_q != SIDE_GREEN) ? 1'b0
                                                                   : (side_pend_q | bus.side_req);
`ifdef PED_WALK_EN
    ped_pend_d  = (state_d == PED_WALK && state_q != PED_WALK) ? 1'b0
                                                               : (ped_pend_q | bus.ped_req);
`endif
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q     <= MAIN_GREEN;
      timer_q     <= '0;
      side_pend_q <= 1'b0;
      lamps_q     <= lamp_decode(MAIN_GREEN);
`ifdef PED_WALK_EN
      ped_pend_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      side_pend_q <= side_pend_d;
      lamps_q     <= lamp_decode(state_d);
`ifdef PED_WALK_EN
      ped_pend_q  <= ped_pend_d;
`endif
    end
  end

  assign bus.main_R  = lamps_q.main_r;
  assign bus.main_G  = lamps_q.main_g;
  assign bus.main_Y  = lamps_q.main_y;
  assign bus.side_R  = lamps_q.side_r;
  assign bus.side_G  = lamps_q.side_g;
  assign bus.side_Y  = lamps_q.side_y;
  assign bus.phase   = state_q;
`ifdef PED_WALK_EN
  assign bus.walk    = lamps_q.walk;
  assign bus.ped_ack = ped_pend_q;
`else
  assign bus.walk    = 1'b0;
  assign bus.ped_ack = 1'b0;
`endif

endmodule
